// File: rtl/mem_snoop_reg_bank_if.sv
// mem_snoop_reg_bank_if: AXI4-Lite port bundle between the PS GP master and the snoop register bank
interface mem_snoop_reg_bank_if #(parameter int AXI_AW = 12);
    logic [AXI_AW-1:0] s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [AXI_AW-1:0] s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
               s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/mem_snoop_reg_bank.sv
// mem_snoop_reg_bank: times fetch-enable to the end-of-test store and exposes the result over AXI4-Lite
module mem_snoop_reg_bank #(
    parameter logic [31:0] END_ADDR = 32'h0010_2000,
    parameter logic [31:0] END_DATA = 32'hDEAD_BEEF,
    parameter int          AXI_AW   = 12
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fetch_enable_i,
    input  logic                data_req_i,
    input  logic                data_gnt_i,
    input  logic                data_we_i,
    input  logic [3:0]          data_be_i,
    input  logic [31:0]         data_addr_i,
    input  logic [31:0]         data_wdata_i,
    mem_snoop_reg_bank_if.slave axi
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam logic [AXI_AW-3:0] R_STAT = 0, R_CYC = 1, R_CTRL = 2, R_MCNT = 3;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
    state_e state_q, state_d;
    logic [31:0] cyc_q, cyc_d, rdata_q, rd_val;
    logic [15:0] mcnt_q, mcnt_d;
    logic [1:0] rresp_q, bresp_q;
    logic ovf_q, ovf_d, fe_q, clr_q, rvalid_q, bvalid_q;
    logic rise, match, ar_hs, aw_hs, unused_ok;
    logic [AXI_AW-3:0] ridx, widx;
    assign rise  = fetch_enable_i & ~fe_q;
    assign match = data_req_i & data_gnt_i & data_we_i & (data_be_i == 4'hF) &
                   (data_addr_i == END_ADDR) & (data_wdata_i == END_DATA);
    assign ridx = axi.s_axi_araddr[AXI_AW-1:2];
    assign widx = axi.s_axi_awaddr[AXI_AW-1:2];
    assign axi.s_axi_arready = ~rvalid_q & ~rst_i;
    assign ar_hs = axi.s_axi_arvalid & axi.s_axi_arready;
    assign aw_hs = axi.s_axi_awvalid & axi.s_axi_wvalid & ~bvalid_q & ~rst_i;
    assign axi.s_axi_awready = aw_hs;
    assign axi.s_axi_wready  = aw_hs;
    assign axi.s_axi_rvalid  = rvalid_q;
    assign axi.s_axi_rdata   = rdata_q;
    assign axi.s_axi_rresp   = rresp_q;
    assign axi.s_axi_bvalid  = bvalid_q;
    assign axi.s_axi_bresp   = bresp_q;
    assign unused_ok = ^{axi.s_axi_wdata[31:1], axi.s_axi_awaddr[1:0], axi.s_axi_araddr[1:0]};
    assign rd_val = ridx == R_STAT ? {29'h0, ovf_q, state_q == RUN, state_q == DONE} :
                    ridx == R_CYC  ? cyc_q :
                    ridx == R_MCNT ? {16'h0, mcnt_q} : 32'h0;
    // the match cycle and the fetch-enable drop cycle are both counted before leaving RUN
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ovf_d   = ovf_q;
        mcnt_d  = (match && mcnt_q != 16'hFFFF) ? mcnt_q + 16'd1 : mcnt_q;
        if (clr_q) begin
            state_d = IDLE;
            cyc_d   = 32'h0;
            ovf_d   = 1'b0;
            mcnt_d  = 16'h0;
        end else if (rise) begin
            state_d = RUN;
            cyc_d   = 32'h0;
            ovf_d   = 1'b0;
        end else if (state_q == RUN) begin
            cyc_d   = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
            ovf_d   = ovf_q | (cyc_q == 32'hFFFF_FFFF);
            state_d = match ? DONE : fetch_enable_i ? RUN : IDLE;
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cyc_q    <= 32'h0;
            ovf_q    <= 1'b0;
            mcnt_q   <= 16'h0;
            fe_q     <= 1'b0;
            clr_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            rresp_q  <= OKAY;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            ovf_q    <= ovf_d;
            mcnt_q   <= mcnt_d;
            fe_q     <= fetch_enable_i;
            clr_q    <= aw_hs & (widx == R_CTRL) & axi.s_axi_wdata[0];
            rvalid_q <= ar_hs | (rvalid_q & ~axi.s_axi_rready);
            bvalid_q <= aw_hs | (bvalid_q & ~axi.s_axi_bready);
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= (ridx <= R_MCNT) ? OKAY : SLVERR;
            end
            if (aw_hs) bresp_q <= (widx == R_CTRL) ? OKAY : SLVERR;
        end
    end
endmodule

// File: doc/mem_snoop_reg_bank.md
Name: mem_snoop_reg_bank

Overview:
- Snoops the RISC-V core's data-memory write port for the end-of-test write of END_DATA to END_ADDR.
- Counts clock cycles from fetch-enable assertion to that write.
- Exposes status and count as a small AXI4-Lite register bank at 0x4000_9000 on the PS GP port, so the host can poll for completion.
- Sits beside the data memory, downstream of the core's LSU; its register bank is read by the PS.

Parameters:
END_ADDR, 32'h0010_2000, core-side byte address of the end-sequence word
END_DATA, 32'hDEADBEEF, end-sequence value
AXI_AW, 12, AXI-Lite address width (4 KB window)

Ports:
clk_i  in  1  system clock (FCLK_CLK0 domain)
rst_i  in  1  reset, asynchronous, active-high
fetch_enable_i  in  1  core fetch enable from reboot block
data_req_i / data_gnt_i / data_we_i  in  1 each  core data port request, grant, write-enable
data_be_i  in  4  byte enables
data_addr_i  in  32  byte address
data_wdata_i  in  32  write data
s_axi_awaddr  in  AXI_AW  write address; s_axi_awvalid in 1; s_axi_awready out 1
s_axi_wdata  in  32; s_axi_wvalid in 1; s_axi_wready out 1
s_axi_bresp  out  2; s_axi_bvalid out 1; s_axi_bready in 1
s_axi_araddr  in  AXI_AW; s_axi_arvalid in 1; s_axi_arready out 1
s_axi_rdata  out  32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1

Behaviour:
- Reset: all registers 0, state IDLE, all AXI valid/ready outputs 0, rdata 0, resp 0.
- Rise detect: fe_q registers fetch_enable_i. rise = fetch_enable_i & ~fe_q.
- Match = data_req_i & data_gnt_i & data_we_i & (data_be_i==4'hF) & (data_addr_i==END_ADDR) & (data_wdata_i==END_DATA). Partial-byte writes never match.
- FSM IDLE / RUN / DONE. Priority per cycle: clear > rise > match > fall.
  - Any state, clear: go to IDLE; cycles=0, done=0, ovf=0.
  - Any state, rise: go to RUN; cycles=0, ovf=0, done=0. Restart is allowed from DONE.
  - RUN: cycles+=1 every cycle. Saturates at 32'hFFFF_FFFF and sets ovf (sticky).
  - RUN, match: cycles+=1 (same cycle), then go to DONE and set done=1. Match together with a falling fetch_enable still goes to DONE.
  - RUN, ~fetch_enable_i without match: go to IDLE, cycles held, done=0 (aborted).
  - IDLE or DONE: matches ignored, cycles held.
  - Count rule: a match N cycles after the rise cycle gives cycles=N.
  - match_cnt (16-bit, saturating) increments on every match in any state. It clears only on clear or reset.
- Register map (byte offset; bits [AXI_AW-1:2] decoded, [1:0] ignored):
  - 0x000 STATUS RO: [0] done, [1] running (state==RUN), [2] ovf, others 0
  - 0x004 CYCLES RO: cycles
  - 0x008 CTRL WO: write with wdata[0]=1 produces a one-cycle clear pulse. Reads return 0.
  - 0x00C MATCHES RO: {16'h0, match_cnt}
- AXI read:
  - arready=1 while ~rvalid. On handshake, rdata is snapshotted from register values at that edge; rvalid rises next cycle and holds, with rdata stable, until rready.
  - rresp OKAY for 0x000–0x00C, SLVERR (2'b10) with rdata=0 otherwise.
  - One outstanding read.
- AXI write:
  - awready=wready=1 only in a cycle where awvalid & wvalid & ~bvalid; both are accepted together.
  - bvalid rises next cycle and holds until bready.
  - bresp OKAY for 0x008, SLVERR for all other addresses (RO writes have no effect).
  - The clear pulse fires in the cycle after acceptance.
- Simultaneous AXI read and write: independent channels. A read in the clear cycle returns pre-clear values.
- Reset mid-operation: asynchronous return to reset values. Any in-flight AXI response is dropped.

Test Plan:
- Rise fetch_enable at cycle 0; write 0xDEADBEEF to 0x0010_2000 with be=F at cycle 100 -> STATUS=0x1, CYCLES=100, MATCHES=1.
- Same write with be=4'h3, or wdata=0xDEADBEEE, or addr=0x0010_2004 -> STATUS=0x2 (running), MATCHES=0.
- Drop fetch_enable at cycle 50 without match -> STATUS=0x0, CYCLES=50. Re-rise -> CYCLES restarts from 0.
- Write 0x1 to 0x008 when STATUS=0x1 -> bresp=OKAY, then STATUS=0, CYCLES=0, MATCHES=0. Write to 0x004 -> bresp=SLVERR, CYCLES unchanged.
- Read 0x010 -> rresp=SLVERR, rdata=0. Hold rready=0 for 5 cycles -> rvalid and rdata stable, arready=0.
- Force cycles to 32'hFFFF_FFFE in RUN -> after 3 cycles CYCLES=0xFFFFFFFF, STATUS[2]=1. Assert rst_i mid-RUN -> all reads return 0.
